hour_chime: RTL
===============

# hour_chime

Hourly chime generator, directly downstream of the seconds-of-day counter: it consumes the 17-bit `cur_sec` value and drives the board speaker. On every transition onto a whole hour it plays a burst of tone beeps, one per hour on a 12-hour dial (00:00/12:00 → 12 beeps, 13:00 → 1 beep). The block runs in the main clock domain beside the seven-segment display path.

## Interface

Parameters:
- `TONE_HALF`, 50000: tone half-period in clk cycles (1 kHz at 100 MHz).
- `BEEP_CYC`, 20000000: length of one beep in clk cycles (200 ms).
- `GAP_CYC`, 20000000: silence between beeps in clk cycles.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-low.
- `en` input 1: chime enable; low aborts any chime and suppresses triggers.
- `cur_sec` input 17: seconds of day, legal range 0..86399.
- `speaker` output 1: square-wave tone, low when silent.
- `busy` output 1: high while a chime sequence is in progress.
- `beeps_left` output 4: beeps remaining, including the one currently sounding.

## Operation

- `prev_sec` register holds the `cur_sec` value from the previous cycle.
- Trigger condition, evaluated every cycle: `en`=1, `cur_sec` != `prev_sec`, `cur_sec` ∈ {0, 3600, …, 82800}, and state is IDLE.
  - The 24 hour-boundary values are detected with constant comparators. No divider.
- Beep count = hour mod 12, with 0 mapped to 12. Range 1..12, held in 4 bits.
- States:
  - IDLE: `speaker`=0, `busy`=0, `beeps_left`=0. On trigger, go to BEEP, load `beeps_left`=count, clear the cycle and tone counters.
  - BEEP: `speaker` toggles every `TONE_HALF` cycles, starting low. After `BEEP_CYC` cycles:
    - decrement `beeps_left`;
    - if the result is 0, go to IDLE;
    - otherwise go to GAP with `speaker` forced low.
  - GAP: `speaker`=0. After `GAP_CYC` cycles, go to BEEP and clear the tone counter so every beep starts low.
- Boundary rules:
  - A trigger while BEEP or GAP is ignored; the sequence in progress finishes unchanged.
  - `cur_sec` ≥ 86400 never triggers.
  - A value that stays constant on an hour boundary triggers once only, because `prev_sec` then equals `cur_sec`.
  - A backward jump onto an hour boundary (a user time set) triggers.
  - `en`=0 in any state: go to IDLE on the next edge; `speaker`, `busy` and `beeps_left` are 0 from then on.
- Counter widths: the cycle counter is wide enough for max(`BEEP_CYC`, `GAP_CYC`); the tone counter is wide enough for `TONE_HALF`.

## Timing

- Reset (`rst`=0 at a clk edge):
  - state = IDLE; `speaker`=0, `busy`=0, `beeps_left`=0;
  - `prev_sec` <= `cur_sec`, so releasing reset while already on an hour does not chime.
- Reset takes priority over everything else, including an active chime.
- Trigger latency: `cur_sec` takes its new hour value in cycle N → at the edge ending cycle N, `busy`=1 and `beeps_left`=count (visible in cycle N+1).
- Tone: first rising edge of `speaker` is `TONE_HALF` cycles after BEEP entry.
- Chime duration: count×`BEEP_CYC` + (count−1)×`GAP_CYC` cycles. There is no trailing gap.
- `busy` falls on the same edge where `beeps_left` becomes 0.

## Configuration

- `HOUR_CHIME_COUNT_EN` defined: beep count = hour on the 12-hour dial, as specified above.
- Not defined:
  - every hour trigger loads `beeps_left`=1, giving a single beep per hour;
  - the hour-to-count mapping logic is not compiled in.

## Test plan

All scenarios use `TONE_HALF`=2, `BEEP_CYC`=8, `GAP_CYC`=4, with `HOUR_CHIME_COUNT_EN` defined unless noted.

- Step `cur_sec` 7199→7200 → `busy`=1 next cycle, `beeps_left`=2; `speaker` toggles every 2 cycles for 8 cycles, is low for 4, toggles for 8, then `busy`=0. Total 20 cycles.
- Step 43199→43200, then separately 86399→0 → `beeps_left`=12 in both cases; 12 beeps, `busy` high for 140 cycles.
- Hold `cur_sec`=3600 during reset, release `rst` → no chime (`busy` stays 0). Then 3601→3600 (backward set) → 1 beep.
- Pulse `rst` low for one edge mid-GAP of a 5-beep chime (5 o'clock) → next cycle `speaker`=0, `busy`=0, `beeps_left`=0.
- `en`=0 while stepping 10799→10800 → no chime. Re-run with `en` dropped mid-BEEP → silent and `busy`=0 on the next cycle. Step to 90000 → no chime.
- Compile without `HOUR_CHIME_COUNT_EN`, step to 39600 → exactly one beep of 8 cycles.

Source files
------------

// File: rtl/hour_chime_if.sv
// Bundle between the seconds-of-day source and the hourly chime block.
// dbg_state mirrors the chime FSM state (0 idle, 1 beep, 2 gap) for observation.
interface hour_chime_if;
  logic        en;
  logic [16:0] cur_sec;
  logic        speaker;
  logic        busy;
  logic [3:0]  beeps_left;
  logic [1:0]  dbg_state;

  // Handshake-free bus: en/cur_sec are level inputs sampled every clk edge; outputs are registered.
  modport master (output en, output cur_sec,
                  input speaker, input busy, input beeps_left, input dbg_state);
  modport slave  (input en, input cur_sec,
                  output speaker, output busy, output beeps_left, output dbg_state);
endinterface

// File: rtl/hour_chime.sv
// Hourly chime: plays one tone burst per hour on the 12-hour dial when cur_sec lands on an hour.
// Optional macro HOUR_CHIME_COUNT_EN: when undefined every hour plays a single beep.
module hour_chime #(
  parameter int TONE_HALF = 50000,
  parameter int BEEP_CYC  = 20000000,
  parameter int GAP_CYC   = 20000000
) (
  input logic        clk,
  input logic        rst,
  hour_chime_if.slave bus
);

  localparam int CYC_MAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int TONE_W  = $clog2(TONE_HALF + 1);

  localparam logic [CYC_W-1:0]  BEEP_LAST = CYC_W'(BEEP_CYC - 1);
  localparam logic [CYC_W-1:0]  GAP_LAST  = CYC_W'(GAP_CYC - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEEP = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [16:0]       prev_sec_q, prev_sec_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              speaker_q, speaker_d;
  logic [3:0]        beeps_q, beeps_d;

  logic       is_hour;
  logic [3:0] count;
  logic       trigger;

  // Constant comparators against the 24 hour boundaries; values >= 86400 never match.
  always_comb begin
    is_hour = 1'b0;
    for (int h = 0; h < 24; h++) begin
      if (bus.cur_sec == 17'(h * 3600)) is_hour = 1'b1;
    end
  end

`ifdef HOUR_CHIME_COUNT_EN
  always_comb begin
    count = 4'd0;
    for (int h = 0; h < 24; h++) begin
      if (bus.cur_sec == 17'(h * 3600)) count = 4'(((h % 12) == 0) ? 12 : (h % 12));
    end
  end
`else
  assign count = 4'd1;
`endif

  assign trigger = bus.en && (bus.cur_sec != prev_sec_q) && is_hour && (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    tone_d     = tone_q;
    speaker_d  = speaker_q;
    beeps_d    = beeps_q;
    prev_sec_d = bus.cur_sec;

    if (!bus.en) begin
      state_d   = S_IDLE;
      cyc_d     = '0;
      tone_d    = '0;
      speaker_d = 1'b0;
      beeps_d   = 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          speaker_d = 1'b0;
          beeps_d   = 4'd0;
          if (trigger) begin
            state_d = S_BEEP;
            beeps_d = count;
            cyc_d   = '0;
            tone_d  = '0;
          end
        end
        S_BEEP: begin
          if (cyc_q == BEEP_LAST) begin
            // The beep just ended: busy drops on the same edge beeps_left hits zero.
            beeps_d   = beeps_q - 4'd1;
            cyc_d     = '0;
            tone_d    = '0;
            speaker_d = 1'b0;
            state_d   = (beeps_q == 4'd1) ? S_IDLE : S_GAP;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
            if (tone_q == TONE_LAST) begin
              tone_d    = '0;
              speaker_d = ~speaker_q;
            end else begin
              tone_d = tone_q + TONE_W'(1);
            end
          end
        end
        S_GAP: begin
          speaker_d = 1'b0;
          if (cyc_q == GAP_LAST) begin
            state_d = S_BEEP;
            cyc_d   = '0;
            tone_d  = '0;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        default: begin
          state_d   = S_IDLE;
          cyc_d     = '0;
          tone_d    = '0;
          speaker_d = 1'b0;
          beeps_d   = 4'd0;
        end
      endcase
    end
  end

  // prev_sec follows cur_sec during reset so leaving reset on an hour stays quiet.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prev_sec_q <= bus.cur_sec;
      cyc_q      <= '0;
      tone_q     <= '0;
      speaker_q  <= 1'b0;
      beeps_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      prev_sec_q <= prev_sec_d;
      cyc_q      <= cyc_d;
      tone_q     <= tone_d;
      speaker_q  <= speaker_d;
      beeps_q    <= beeps_d;
    end
  end

  assign bus.speaker    = speaker_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.beeps_left = beeps_q;
  assign bus.dbg_state  = state_q;

endmodule
